gate_driver_deadtime: RTL and testbench

GATE_DRIVER_DEADTIME -- requirements
Module: gate_driver_deadtime

---
 rtl/gate_driver_pkg.sv | 17 +
 rtl/gate_driver_deadtime_counter.sv | 29 ++
 rtl/gate_driver_deadtime.sv | 118 +++++++++++
 tb/tb_gate_driver_deadtime.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_driver_pkg.sv
// Shared state encoding and gate patterns for the H-bridge dead-time driver.
package gate_driver_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ON_P  = 3'd1,
        DEAD  = 3'd2,
        ON_N  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Gate commands ordered {Q1,Q2,Q3,Q4}
    localparam logic [3:0] PAT_P   = 4'b1001;
    localparam logic [3:0] PAT_N   = 4'b0110;
    localparam logic [3:0] PAT_OFF = 4'b0000;

endpackage

// File: rtl/gate_driver_deadtime_counter.sv
// Loadable dead-time down-counter; a zero load is clamped to one so every
// dead interval has at least one all-off cycle.
module deadtime_counter #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DT_WIDTH-1:0] load_value,
    input  logic                decrement,
    output logic                done
);

    logic [DT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= (load_value == '0) ? DT_WIDTH'(1) : load_value;
        end else if (decrement && (count > DT_WIDTH'(1))) begin
            count <= count - DT_WIDTH'(1);
        end
    end

    // Done on the last dead cycle, so the leg switches on the same edge
    assign done = (count == DT_WIDTH'(1));

endmodule

// File: rtl/gate_driver_deadtime.sv
// H-bridge gate driver: applies the requested leg with a programmable
// all-off dead interval between legs, plus fault latching and event counting.
module gate_driver_deadtime
    import gate_driver_pkg::*;
#(
    parameter int DT_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clock,
    input  logic                 i_RESET,
    input  logic                 i_sigma,
    input  logic                 i_enable,
    input  logic [DT_WIDTH-1:0]  i_deadtime,
    input  logic                 i_fault,
    input  logic                 i_fault_clear,
    output logic [3:0]           o_MOSFET,
    output logic                 o_sigma,
    output logic                 o_dead,
    output logic                 o_fault,
    output logic [CNT_WIDTH-1:0] o_switch_count
);

    state_t state;
    logic   dt_load;
    logic   dt_done;

    // Load the dead-time count on the edge that moves the FSM into DEAD
    always_comb begin
        dt_load = 1'b0;
        if (!i_fault && i_enable) begin
            case (state)
                IDLE:    dt_load = 1'b1;
                ON_P:    dt_load = !i_sigma;
                ON_N:    dt_load = i_sigma;
                default: dt_load = 1'b0;
            endcase
        end
    end

    deadtime_counter #(
        .DT_WIDTH(DT_WIDTH)
    ) u_deadtime_counter (
        .clk        (i_clock),
        .rst        (i_RESET),
        .load       (dt_load),
        .load_value (i_deadtime),
        .decrement  (state == DEAD),
        .done       (dt_done)
    );

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state          <= IDLE;
            o_MOSFET       <= PAT_OFF;
            o_sigma        <= 1'b1;
            o_dead         <= 1'b0;
            o_fault        <= 1'b0;
            o_switch_count <= '0;
        end else if (i_fault) begin
            state    <= FAULT;
            o_MOSFET <= PAT_OFF;
            o_dead   <= 1'b0;
            o_fault  <= 1'b1;
        end else if (state == FAULT) begin
            if (i_fault_clear) begin
                state   <= IDLE;
                o_fault <= 1'b0;
            end
        end else if (!i_enable) begin
            state    <= IDLE;
            o_MOSFET <= PAT_OFF;
            o_dead   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= DEAD;
                    o_MOSFET <= PAT_OFF;
                    o_dead   <= 1'b1;
                end
                ON_P: begin
                    if (!i_sigma) begin
                        state    <= DEAD;
                        o_MOSFET <= PAT_OFF;
                        o_dead   <= 1'b1;
                    end
                end
                ON_N: begin
                    if (i_sigma) begin
                        state    <= DEAD;
                        o_MOSFET <= PAT_OFF;
                        o_dead   <= 1'b1;
                    end
                end
                DEAD: begin
                    // Leg is chosen from i_sigma on the expiry cycle; either leg is legal
                    if (dt_done) begin
                        o_dead         <= 1'b0;
                        o_sigma        <= i_sigma;
                        o_switch_count <= o_switch_count + 1'b1;
                        if (i_sigma) begin
                            state    <= ON_P;
                            o_MOSFET <= PAT_P;
                        end else begin
                            state    <= ON_N;
                            o_MOSFET <= PAT_N;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_MOSFET <= PAT_OFF;
                    o_dead   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_driver_deadtime.sv
// Directed bench for gate_driver_deadtime; observed vector is {o_MOSFET,o_sigma,o_dead,o_fault}.
module tb_gate_driver_deadtime;

    localparam int DW = 8;
    localparam int CW = 8;  // narrow event counter so the wrap is reachable quickly

    logic          clock = 1'b0;
    logic          reset;
    logic          sigma;
    logic          enable;
    logic          fault;
    logic          fault_clear;
    logic [DW-1:0] deadtime;
    logic [3:0]    mosfet;
    logic          sigma_out;
    logic          dead;
    logic          fault_out;
    logic [CW-1:0] count;
    logic [6:0]    obs;

    int total = 0;
    int bad   = 0;

    gate_driver_deadtime #(
        .DT_WIDTH  (DW),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clock        (clock),
        .i_RESET        (reset),
        .i_sigma        (sigma),
        .i_enable       (enable),
        .i_deadtime     (deadtime),
        .i_fault        (fault),
        .i_fault_clear  (fault_clear),
        .o_MOSFET       (mosfet),
        .o_sigma        (sigma_out),
        .o_dead         (dead),
        .o_fault        (fault_out),
        .o_switch_count (count)
    );

    always #5 clock = ~clock;

    assign obs = {mosfet, sigma_out, dead, fault_out};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sigma = 1'b0; enable = 1'b0; fault = 1'b0;
        fault_clear = 1'b0; deadtime = '0;
        step(); step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 7'b0000_1_0_0);
        end
        total++;
        if (count !== 8'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", count);
        end
        reset = 1'b0;
    endtask

    task automatic test_startup();
        enable = 1'b1; sigma = 1'b1; deadtime = 8'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs !== 7'b0000_1_1_0) begin
                bad++; $display("FAIL startup_dead%0d got=%b want=%b", i, obs, 7'b0000_1_1_0);
            end
        end
        step();
        total++;
        if (obs !== 7'b1001_1_0_0) begin
            bad++; $display("FAIL startup_onp got=%b want=%b", obs, 7'b1001_1_0_0);
        end
        total++;
        if (count !== 8'd1) begin
            bad++; $display("FAIL startup_count got=%0d want=1", count);
        end
    endtask

    task automatic test_toggle();
        sigma = 1'b0; deadtime = 8'd3;
        step();
        total++;
        if (obs !== 7'b0000_1_1_0) begin
            bad++; $display("FAIL toggle_dead0 got=%b want=%b", obs, 7'b0000_1_1_0);
        end
        deadtime = 8'd9;  // must not stretch the interval already loaded
        for (int i = 1; i < 3; i++) begin
            step();
            total++;
            if (obs !== 7'b0000_1_1_0) begin
                bad++; $display("FAIL toggle_dead%0d got=%b want=%b", i, obs, 7'b0000_1_1_0);
            end
        end
        step();
        total++;
        if (obs !== 7'b0110_0_0_0) begin
            bad++; $display("FAIL toggle_onn got=%b want=%b", obs, 7'b0110_0_0_0);
        end
        total++;
        if (count !== 8'd2) begin
            bad++; $display("FAIL toggle_count got=%0d want=2", count);
        end
    endtask

    task automatic test_zero_deadtime();
        deadtime = 8'd0; sigma = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_0_1_0) begin
            bad++; $display("FAIL zero_dt_dead got=%b want=%b", obs, 7'b0000_0_1_0);
        end
        step();
        total++;
        if (obs !== 7'b1001_1_0_0) begin
            bad++; $display("FAIL zero_dt_onp got=%b want=%b", obs, 7'b1001_1_0_0);
        end
        total++;
        if (count !== 8'd3) begin
            bad++; $display("FAIL zero_dt_count got=%0d want=3", count);
        end
    endtask

    task automatic test_return_leg();
        deadtime = 8'd2; sigma = 1'b0;
        step();
        sigma = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_1_0) begin
            bad++; $display("FAIL return_dead got=%b want=%b", obs, 7'b0000_1_1_0);
        end
        step();
        total++;
        if (obs !== 7'b1001_1_0_0) begin
            bad++; $display("FAIL return_onp got=%b want=%b", obs, 7'b1001_1_0_0);
        end
        total++;
        if (count !== 8'd4) begin
            bad++; $display("FAIL return_count got=%0d want=4", count);
        end
    endtask

    task automatic test_disable();
        deadtime = 8'd5; sigma = 1'b0;
        step();
        enable = 1'b0;
        step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL disable_idle got=%b want=%b", obs, 7'b0000_1_0_0);
        end
        step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL disable_hold got=%b want=%b", obs, 7'b0000_1_0_0);
        end
        enable = 1'b1; sigma = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_1_0) begin
            bad++; $display("FAIL disable_restart got=%b want=%b", obs, 7'b0000_1_1_0);
        end
    endtask

    task automatic test_fault();
        step();
        fault = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_0_1) begin
            bad++; $display("FAIL fault_enter got=%b want=%b", obs, 7'b0000_1_0_1);
        end
        fault_clear = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_0_1) begin
            bad++; $display("FAIL fault_clear_ignored got=%b want=%b", obs, 7'b0000_1_0_1);
        end
        fault = 1'b0; fault_clear = 1'b0;
        step();
        total++;
        if (obs !== 7'b0000_1_0_1) begin
            bad++; $display("FAIL fault_hold got=%b want=%b", obs, 7'b0000_1_0_1);
        end
        fault_clear = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL fault_exit got=%b want=%b", obs, 7'b0000_1_0_0);
        end
        fault_clear = 1'b0;
        step();
        total++;
        if (obs !== 7'b0000_1_1_0) begin
            bad++; $display("FAIL fault_rearm got=%b want=%b", obs, 7'b0000_1_1_0);
        end
        total++;
        if (count !== 8'd4) begin
            bad++; $display("FAIL fault_count got=%0d want=4", count);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b1; deadtime = 8'd0;
        for (int i = 0; i < 255; i++) begin
            sigma = (i % 2 == 0);
            step();
            total++;
            if (mosfet !== 4'b0000) begin
                bad++; $display("FAIL wrap_dead%0d got=%b want=0000", i, mosfet);
            end
            step();
            total++;
            if (count !== 8'(i + 1)) begin
                bad++; $display("FAIL wrap_count%0d got=%0d want=%0d", i, count, i + 1);
            end
        end
        total++;
        if (obs !== 7'b1001_1_0_0) begin
            bad++; $display("FAIL wrap_pre got=%b want=%b", obs, 7'b1001_1_0_0);
        end
        sigma = 1'b0;
        step(); step();
        total++;
        if (obs !== 7'b0110_0_0_0) begin
            bad++; $display("FAIL wrap_onn got=%b want=%b", obs, 7'b0110_0_0_0);
        end
        total++;
        if (count !== 8'd0) begin
            bad++; $display("FAIL wrap_zero got=%0d want=0", count);
        end
    endtask

    task automatic test_reset_priority();
        fault = 1'b1; reset = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL rstprio_outputs got=%b want=%b", obs, 7'b0000_1_0_0);
        end
        total++;
        if (count !== 8'd0) begin
            bad++; $display("FAIL rstprio_count got=%0d want=0", count);
        end
        reset = 1'b0; fault = 1'b0; enable = 1'b1; deadtime = 8'd5; sigma = 1'b1;
        step();
        reset = 1'b1;
        step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL rst_middead got=%b want=%b", obs, 7'b0000_1_0_0);
        end
        reset = 1'b0; enable = 1'b0;
        step();
        total++;
        if (obs !== 7'b0000_1_0_0) begin
            bad++; $display("FAIL rst_idle_hold got=%b want=%b", obs, 7'b0000_1_0_0);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_toggle();
        test_zero_deadtime();
        test_return_leg();
        test_disable();
        test_fault();
        test_wrap();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
